ex_retire_sequencer: RTL and testbench

- Sits at the back of EX, between the execution units (ALU, MUL, DIV, FPU) and the EX/MEM boundary.
- Records the unit each instruction is issued to, in issue order, in a small FIFO.
- Accepts results only from the unit at the FIFO head, so multi-cycle units retire strictly in program order.
- Drives the single valid/ready result channel into MEM.

---
 rtl/ex_retire_sequencer.sv | 111 +++++++++++
 tb/tb_ex_retire_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_retire_sequencer.sv
// ex_retire_sequencer
// Purpose: records, in issue order, the execution unit (ALU/MUL/DIV/FPU) that
// each instruction was sent to. Only the unit at the head of that record may
// hand its result to MEM, so multi-cycle units retire strictly in program order.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   issue_valid/_unit     issue record from ID (unit index 0=ALU 1=MUL 2=DIV 3=FPU)
//   issue_ready           record FIFO has space
//   res_valid/res_ready   per-unit result handshake
//   res_rd_wena/addr/data per-unit result payload, packed by unit index
//   valid_out/ready_in    result channel into MEM
//   rd_wena_out/rd_addr_out/rd_data_out/unit_out  selected head-unit result
//   inflight              number of recorded, not yet retired instructions
module ex_retire_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned UNITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [1:0]            issue_unit,
    output logic                  issue_ready,
    input  logic [UNITS-1:0]      res_valid,
    output logic [UNITS-1:0]      res_ready,
    input  logic [UNITS-1:0]      res_rd_wena,
    input  logic [6*UNITS-1:0]    res_rd_addr,
    input  logic [32*UNITS-1:0]   res_rd_data,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  rd_wena_out,
    output logic [5:0]            rd_addr_out,
    output logic [31:0]           rd_data_out,
    output logic [1:0]            unit_out,
    output logic [$clog2(DEPTH):0] inflight
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [1:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic [1:0] head;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign head        = fifo_q[rd_ptr_q];
    // Ready depends only on occupancy: a retire this cycle frees the slot next cycle.
    assign issue_ready = !full;
    assign push        = issue_valid && issue_ready;
    assign pop         = valid_out && ready_in;
    assign inflight    = count_q;

    // Head-unit result mux and per-unit accept
    always_comb begin
        valid_out   = 1'b0;
        rd_wena_out = 1'b0;
        rd_addr_out = '0;
        rd_data_out = '0;
        unit_out    = '0;
        res_ready   = '0;
        if (!empty) begin
            unit_out = head;
            for (int i = 0; i < UNITS; i++) begin
                if (head == 2'(i)) begin
                    valid_out    = res_valid[i];
                    rd_wena_out  = res_rd_wena[i];
                    rd_addr_out  = res_rd_addr[6*i +: 6];
                    rd_data_out  = res_rd_data[32*i +: 32];
                    res_ready[i] = ready_in;
                end
            end
        end
    end

    // Issue-order storage; contents are only observed while non-empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= issue_unit;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_retire_sequencer.sv
// Randomized bench for ex_retire_sequencer against a queue-based model of
// program order and of four units that each complete their own work in order
// after a random latency and hold their result until it is accepted.
module tb_ex_retire_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned UNITS = 4;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic [1:0]    issue_unit;
    logic          issue_ready;
    logic [3:0]    res_valid;
    logic [3:0]    res_ready;
    logic [3:0]    res_rd_wena;
    logic [23:0]   res_rd_addr;
    logic [127:0]  res_rd_data;
    logic          valid_out;
    logic          ready_in;
    logic          rd_wena_out;
    logic [5:0]    rd_addr_out;
    logic [31:0]   rd_data_out;
    logic [1:0]    unit_out;
    logic [2:0]    inflight;

    ex_retire_sequencer #(.DEPTH(DEPTH), .UNITS(UNITS)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_rd_wena(res_rd_wena),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
        .valid_out(valid_out), .ready_in(ready_in),
        .rd_wena_out(rd_wena_out), .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out),
        .unit_out(unit_out), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  unit;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        wena;
        int          rdy;
    } rec_t;

    rec_t iq[$];        // program order of outstanding instructions
    rec_t uq[4][$];     // per-unit outstanding work, oldest first

    int n_checks = 0;
    int n_errors = 0;
    int n_retired = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0;
        issue_unit  = 2'd0;
        ready_in    = 1'b0;
        res_valid   = '0;
        res_rd_wena = '0;
        res_rd_addr = '0;
        res_rd_data = '0;
    endtask

    // Each unit shows its oldest job once its latency has elapsed; others show junk.
    task automatic drive_units(input int cyc);
        for (int u = 0; u < 4; u++) begin
            if (uq[u].size() > 0 && cyc >= uq[u][0].rdy) begin
                res_valid[u]           = 1'b1;
                res_rd_wena[u]         = uq[u][0].wena;
                res_rd_addr[6*u +: 6]  = uq[u][0].addr;
                res_rd_data[32*u +: 32] = uq[u][0].data;
            end else begin
                res_valid[u]           = 1'b0;
                res_rd_wena[u]         = 1'($urandom_range(0, 1));
                res_rd_addr[6*u +: 6]  = 6'($urandom);
                res_rd_data[32*u +: 32] = $urandom;
            end
        end
    endtask

    initial begin
        logic       exp_valid;
        logic       exp_push;
        logic [3:0] exp_rr;
        logic [1:0] hu;
        rec_t       r;

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_res_ready", 64'(res_ready), 64'd0);

        // Fill three entries, then reset asynchronously between clock edges
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            issue_valid = 1'b1;
            issue_unit  = 2'(k + 1);
            @(posedge clk);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        ready_in    = 1'b1;
        #1;
        check("pre_rst_inflight", 64'(inflight), 64'd3);
        reset = 1'b1;
        #1;
        check("async_rst_inflight", 64'(inflight), 64'd0);
        check("async_rst_valid_out", 64'(valid_out), 64'd0);
        check("async_rst_issue_ready", 64'(issue_ready), 64'd1);
        check("async_rst_res_ready", 64'(res_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_unit  = 2'($urandom_range(0, 3));
            ready_in    = ($urandom_range(0, 9) < 7);
            drive_units(c);
            #1;

            exp_valid = 1'b0;
            exp_rr    = '0;
            hu        = 2'd0;
            if (iq.size() > 0) begin
                hu        = iq[0].unit;
                exp_valid = (uq[hu].size() > 0) && (c >= uq[hu][0].rdy);
                exp_rr[hu] = ready_in;
            end
            exp_push = issue_valid && (iq.size() < DEPTH);

            check("inflight", 64'(inflight), 64'(iq.size()));
            check("issue_ready", 64'(issue_ready), 64'(iq.size() < DEPTH));
            check("valid_out", 64'(valid_out), 64'(exp_valid));
            check("res_ready", 64'(res_ready), 64'(exp_rr));
            if (exp_valid) begin
                check("unit_out", 64'(unit_out), 64'(iq[0].unit));
                check("rd_addr_out", 64'(rd_addr_out), 64'(iq[0].addr));
                check("rd_data_out", 64'(rd_data_out), 64'(iq[0].data));
                check("rd_wena_out", 64'(rd_wena_out), 64'(iq[0].wena));
            end

            @(posedge clk);
            if (exp_valid && ready_in) begin
                void'(iq.pop_front());
                void'(uq[hu].pop_front());
                n_retired++;
            end
            if (exp_push) begin
                r.unit = issue_unit;
                r.addr = 6'($urandom);
                r.data = $urandom;
                r.wena = 1'($urandom_range(0, 1));
                r.rdy  = c + 1 + int'($urandom_range(0, 5));
                iq.push_back(r);
                uq[issue_unit].push_back(r);
            end
        end

        check("retired_some", 64'(n_retired > 500), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
